forward_cfg_loader: RTL and testbench

Writes and commits the 8-bit forward-selection control words (`cfg_forward_ctrl`) for a column of NUM_BLK cascaded RAM blocks.
- Accepts write, read, clear and commit commands over a valid/ready command port and answers each one on a valid/ready response port.
- Keeps a shadow and an active copy of every control word.
- Active words feed the forward-selection muxes and change only during a commit, so a column is never partially reconfigured by single writes.

---
 rtl/forward_cfg_pkg.sv | 19 +
 rtl/forward_cfg_slot.sv | 32 +++
 rtl/forward_cfg_loader.sv | 138 +++++++++++++
 tb/tb_forward_cfg_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_cfg_pkg.sv
// Shared constants for the forward-selection config loader:
// opcodes, word width, reset value and FSM encoding.
package forward_cfg_pkg;

   localparam int CFG_W = 8;

   localparam logic [7:0] CFG_RST_VAL = 8'h00;

   localparam logic [1:0] OP_WRITE  = 2'b00;
   localparam logic [1:0] OP_COMMIT = 2'b01;
   localparam logic [1:0] OP_READ   = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   typedef enum logic {
      ST_IDLE,
      ST_COMMIT
   } state_t;

endpackage

// File: rtl/forward_cfg_slot.sv
// Shadow/active control-word pair for one RAM block.
// Shadow takes writes and clears; active only loads on commit.
module forward_cfg_slot
   import forward_cfg_pkg::*;
#(
   parameter int W = CFG_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         clr_i,
   input  logic         commit_i,
   output logic [W-1:0] shadow_o,
   output logic [W-1:0] active_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_o <= W'(CFG_RST_VAL);
         active_o <= W'(CFG_RST_VAL);
      end else begin
         if (clr_i)
            shadow_o <= W'(CFG_RST_VAL);
         else if (wr_en_i)
            shadow_o <= wr_data_i;
         if (commit_i)
            active_o <= shadow_o;
      end
   end

endmodule

// File: rtl/forward_cfg_loader.sv
// Command-driven loader for the forward-selection words of a
// RAM cascade column; active words change only via commit.
module forward_cfg_loader
   import forward_cfg_pkg::*;
#(
   parameter int NUM_BLK = 4,
   parameter int CFG_W   = forward_cfg_pkg::CFG_W,
   parameter int AW      = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [1:0]               cmd_op_i,
   input  logic [AW-1:0]            cmd_addr_i,
   input  logic [CFG_W-1:0]         cmd_data_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [CFG_W-1:0]         rsp_data_o,
   output logic                     rsp_err_o,
   output logic [NUM_BLK*CFG_W-1:0] cfg_forward_ctrl_o,
   output logic                     cfg_pending_o
);

   localparam int CW = $clog2(NUM_BLK + 1);

   state_t            state;
   logic [CW-1:0]     cnt;
   logic              accept;
   logic              addr_ok;
   logic              clr;
   logic [NUM_BLK-1:0] wr_en;
   logic [NUM_BLK-1:0] commit_en;
   logic [CFG_W-1:0]  shadow [NUM_BLK];
   logic [CFG_W-1:0]  active [NUM_BLK];
   logic [CFG_W-1:0]  rd_shadow;
   logic [CFG_W-1:0]  rd_active;

   assign cmd_ready_o = (state == ST_IDLE) &&
                        (!rsp_valid_o || rsp_ready_i);
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign addr_ok     = 32'(cmd_addr_i) < NUM_BLK;
   assign clr         = accept && (cmd_op_i == OP_CLEAR);

   always_comb begin
      wr_en              = '0;
      commit_en          = '0;
      rd_shadow          = '0;
      rd_active          = '0;
      cfg_pending_o      = 1'b0;
      cfg_forward_ctrl_o = '0;
      for (int k = 0; k < NUM_BLK; k++) begin
         wr_en[k]     = accept && (cmd_op_i == OP_WRITE) &&
                        (cmd_addr_i == AW'(k));
         commit_en[k] = (state == ST_COMMIT) && (cnt == CW'(k));
         if (cmd_addr_i == AW'(k)) begin
            rd_shadow = shadow[k];
            rd_active = active[k];
         end
         if (shadow[k] != active[k])
            cfg_pending_o = 1'b1;
         cfg_forward_ctrl_o[k*CFG_W +: CFG_W] = active[k];
      end
   end

   for (genvar k = 0; k < NUM_BLK; k++) begin : g_slot
      forward_cfg_slot #(
         .W(CFG_W)
      ) u_slot (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .wr_en_i   (wr_en[k]),
         .wr_data_i (cmd_data_i),
         .clr_i     (clr),
         .commit_i  (commit_en[k]),
         .shadow_o  (shadow[k]),
         .active_o  (active[k])
      );
   end

   // cnt == NUM_BLK is the cycle after the last copy, where the
   // commit response is raised and the FSM returns to IDLE.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         if (rsp_valid_o && rsp_ready_i)
            rsp_valid_o <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  unique case (cmd_op_i)
                     OP_COMMIT: begin
                        state <= ST_COMMIT;
                        cnt   <= '0;
                     end
                     OP_WRITE: begin
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= addr_ok ? cmd_data_i : '0;
                        rsp_err_o   <= !addr_ok;
                     end
                     OP_READ: begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= !addr_ok;
                        if (!addr_ok)
                           rsp_data_o <= '0;
                        else if (cmd_data_i[0])
                           rsp_data_o <= rd_shadow;
                        else
                           rsp_data_o <= rd_active;
                     end
                     OP_CLEAR: begin
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= '0;
                        rsp_err_o   <= 1'b0;
                     end
                  endcase
               end
            end
            ST_COMMIT: begin
               if (cnt == CW'(NUM_BLK)) begin
                  state       <= ST_IDLE;
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= '0;
                  rsp_err_o   <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_forward_cfg_loader.sv
// Directed bench for forward_cfg_loader with a cycle-level
// reference model checked on every cycle after reset.
module tb_forward_cfg_loader;
   import forward_cfg_pkg::*;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [1:0]    cmd_op_i;
   logic [AW-1:0] cmd_addr_i;
   logic [W-1:0]  cmd_data_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [W-1:0]  rsp_data_o;
   logic          rsp_err_o;
   logic [N*W-1:0] cfg_forward_ctrl_o;
   logic          cfg_pending_o;

   always #5 clk = ~clk;

   forward_cfg_loader #(
      .NUM_BLK(N),
      .CFG_W  (W),
      .AW     (AW)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .cmd_valid_i        (cmd_valid_i),
      .cmd_ready_o        (cmd_ready_o),
      .cmd_op_i           (cmd_op_i),
      .cmd_addr_i         (cmd_addr_i),
      .cmd_data_i         (cmd_data_i),
      .rsp_valid_o        (rsp_valid_o),
      .rsp_ready_i        (rsp_ready_i),
      .rsp_data_o         (rsp_data_o),
      .rsp_err_o          (rsp_err_o),
      .cfg_forward_ctrl_o (cfg_forward_ctrl_o),
      .cfg_pending_o      (cfg_pending_o)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit started = 1'b0;

   logic [W-1:0] m_sh  [N];
   logic [W-1:0] m_act [N];
   bit           m_commit = 1'b0;
   int           m_ct = 0;
   bit           m_rv = 1'b0;
   logic [W-1:0] m_rd = '0;
   bit           m_re = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Reference model: commands take effect at the accepting edge;
   // a commit accepted at edge T copies block k at edge T+1+k and
   // answers at edge T+N+1.
   always @(posedge clk) begin : model
      bit rdy;
      bit was_c;
      int a;
      int k;
      cyc++;
      if (rst_i) begin
         for (int i = 0; i < N; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
         end
         m_commit = 1'b0;
         m_rv     = 1'b0;
         m_rd     = '0;
         m_re     = 1'b0;
         started  = 1'b1;
      end else if (started) begin
         was_c = m_commit;
         rdy   = !m_commit && (!m_rv || rsp_ready_i);
         if (m_rv && rsp_ready_i)
            m_rv = 1'b0;
         if (cmd_valid_i && rdy) begin
            a = int'(cmd_addr_i);
            case (cmd_op_i)
               OP_WRITE: begin
                  m_rv = 1'b1;
                  if (a < N) begin
                     m_sh[a] = cmd_data_i;
                     m_rd = cmd_data_i;
                     m_re = 1'b0;
                  end else begin
                     m_rd = '0;
                     m_re = 1'b1;
                  end
               end
               OP_READ: begin
                  m_rv = 1'b1;
                  if (a < N) begin
                     m_rd = cmd_data_i[0] ? m_sh[a] : m_act[a];
                     m_re = 1'b0;
                  end else begin
                     m_rd = '0;
                     m_re = 1'b1;
                  end
               end
               OP_CLEAR: begin
                  for (int i = 0; i < N; i++) m_sh[i] = '0;
                  m_rv = 1'b1;
                  m_rd = '0;
                  m_re = 1'b0;
               end
               default: begin
                  m_commit = 1'b1;
                  m_ct = cyc;
               end
            endcase
         end
         if (was_c) begin
            k = cyc - m_ct - 1;
            if (k >= 0 && k < N)
               m_act[k] = m_sh[k];
            if (cyc == m_ct + N + 1) begin
               m_commit = 1'b0;
               m_rv = 1'b1;
               m_rd = '0;
               m_re = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [N*W-1:0] e_ctrl;
      bit e_pend;
      if (started) begin
         e_pend = 1'b0;
         for (int i = 0; i < N; i++) begin
            e_ctrl[i*W +: W] = m_act[i];
            if (m_sh[i] != m_act[i]) e_pend = 1'b1;
         end
         chk("cmd_ready", 64'(cmd_ready_o),
             64'(!m_commit && (!m_rv || rsp_ready_i)));
         chk("rsp_valid", 64'(rsp_valid_o), 64'(m_rv));
         if (m_rv) begin
            chk("rsp_data", 64'(rsp_data_o), 64'(m_rd));
            chk("rsp_err", 64'(rsp_err_o), 64'(m_re));
         end
         chk("ctrl", 64'(cfg_forward_ctrl_o), 64'(e_ctrl));
         chk("pending", 64'(cfg_pending_o), 64'(e_pend));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input int a,
                       input logic [W-1:0] d);
      bit ok;
      ok = 1'b0;
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_addr_i  = AW'(a);
      cmd_data_i  = d;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready_o) ok = 1'b1;
         tick();
      end
      cmd_valid_i = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got no ready expected ready");
      end
   endtask

   task automatic get_rsp(output logic [W-1:0] d, output logic e);
      bit ok;
      ok = 1'b0;
      d = 'x;
      e = 1'bx;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (rsp_valid_o && rsp_ready_i) begin
            ok = 1'b1;
            d = rsp_data_o;
            e = rsp_err_o;
         end
         tick();
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rsp_timeout: got no response expected one");
      end
   endtask

   task automatic xact(input logic [1:0] op, input int a,
                       input logic [W-1:0] d,
                       output logic [W-1:0] rd, output logic re);
      send(op, a, d);
      get_rsp(rd, re);
   endtask

   task automatic rd_chk(input string nm, input int a, input bit sh,
                         input logic [W-1:0] ed, input bit ee);
      logic [W-1:0] d;
      logic e;
      xact(OP_READ, a, {7'b0, sh}, d, e);
      chk(nm, 64'(d), 64'(ed));
      chk({nm, "_err"}, 64'(e), 64'(ee));
   endtask

   logic [W-1:0] rd;
   logic         re;

   initial begin
      rst_i       = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_op_i    = OP_WRITE;
      cmd_addr_i  = '0;
      cmd_data_i  = '0;
      rsp_ready_i = 1'b1;
      repeat (3) tick();
      rst_i = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_rsp_data", 64'(rsp_data_o), 64'h0);
      chk("rst_ctrl", 64'(cfg_forward_ctrl_o), 64'h0);
      chk("rst_pending", 64'(cfg_pending_o), 64'h0);
      tick();
      for (int a = 0; a < N; a++) begin
         rd_chk("rst_rd_act", a, 1'b0, 8'h00, 1'b0);
         rd_chk("rst_rd_sh", a, 1'b1, 8'h00, 1'b0);
      end

      // write then commit with exact timing
      xact(OP_WRITE, 2, 8'hA5, rd, re);
      chk("wr_rsp", 64'(rd), 64'hA5);
      chk("wr_err", 64'(re), 64'h0);
      chk("wr_pending", 64'(cfg_pending_o), 64'h1);
      cmd_valid_i = 1'b1;
      cmd_op_i    = OP_COMMIT;
      cmd_addr_i  = '0;
      cmd_data_i  = '0;
      @(negedge clk);
      chk("commit_rdy", 64'(cmd_ready_o), 64'h1);
      tick();
      cmd_valid_i = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         @(negedge clk);
         chk("commit_blk2", 64'(cfg_forward_ctrl_o[23:16]),
             (i >= 3) ? 64'hA5 : 64'h0);
         chk("commit_pend", 64'(cfg_pending_o), (i < 3) ? 64'h1 : 64'h0);
         chk("commit_rspv", 64'(rsp_valid_o), (i == 5) ? 64'h1 : 64'h0);
         chk("commit_busy", 64'(cmd_ready_o), (i == 5) ? 64'h1 : 64'h0);
      end
      chk("commit_rspd", 64'(rsp_data_o), 64'h0);
      tick();
      rd_chk("act2", 2, 1'b0, 8'hA5, 1'b0);

      // out-of-range address
      xact(OP_WRITE, 4, 8'h77, rd, re);
      chk("oor_wr_data", 64'(rd), 64'h0);
      chk("oor_wr_err", 64'(re), 64'h1);
      rd_chk("oor_rd", 4, 1'b1, 8'h00, 1'b1);
      rd_chk("oor_sh2", 2, 1'b1, 8'hA5, 1'b0);
      chk("oor_ctrl", 64'(cfg_forward_ctrl_o), 64'h00A5_0000);
      chk("oor_pend", 64'(cfg_pending_o), 64'h0);

      // response back-pressure
      xact(OP_WRITE, 1, 8'h3C, rd, re);
      xact(OP_COMMIT, 0, 8'h00, rd, re);
      rsp_ready_i = 1'b0;
      send(OP_READ, 1, 8'h00);
      cmd_valid_i = 1'b1;
      cmd_op_i    = OP_READ;
      cmd_addr_i  = AW'(1);
      cmd_data_i  = 8'h01;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_ready", 64'(cmd_ready_o), 64'h0);
         chk("bp_valid", 64'(rsp_valid_o), 64'h1);
         chk("bp_data", 64'(rsp_data_o), 64'h3C);
         tick();
      end
      rsp_ready_i = 1'b1;
      @(negedge clk);
      chk("bp_release", 64'(cmd_ready_o), 64'h1);
      chk("bp_data_last", 64'(rsp_data_o), 64'h3C);
      tick();
      cmd_valid_i = 1'b0;
      get_rsp(rd, re);
      chk("bp_next", 64'(rd), 64'h3C);
      chk("bp_next_err", 64'(re), 64'h0);

      // clear and compare
      for (int a = 0; a < N; a++) xact(OP_WRITE, a, 8'hFF, rd, re);
      xact(OP_COMMIT, 0, 8'h00, rd, re);
      xact(OP_CLEAR, 0, 8'h00, rd, re);
      chk("clr_rsp", 64'(rd), 64'h0);
      for (int a = 0; a < N; a++) begin
         rd_chk("clr_sh", a, 1'b1, 8'h00, 1'b0);
         rd_chk("clr_act", a, 1'b0, 8'hFF, 1'b0);
      end
      chk("clr_pend", 64'(cfg_pending_o), 64'h1);
      chk("clr_ctrl", 64'(cfg_forward_ctrl_o), 64'hFFFF_FFFF);

      // reset in the middle of a commit
      xact(OP_WRITE, 0, 8'h11, rd, re);
      xact(OP_WRITE, 1, 8'h22, rd, re);
      xact(OP_WRITE, 2, 8'h33, rd, re);
      xact(OP_WRITE, 3, 8'h44, rd, re);
      send(OP_COMMIT, 0, 8'h00);
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      @(negedge clk);
      chk("mrst_ctrl", 64'(cfg_forward_ctrl_o), 64'h0);
      chk("mrst_pend", 64'(cfg_pending_o), 64'h0);
      chk("mrst_rspv", 64'(rsp_valid_o), 64'h0);
      chk("mrst_ready", 64'(cmd_ready_o), 64'h1);
      for (int i = 0; i < 6; i++) begin
         tick();
         @(negedge clk);
         chk("mrst_norsp", 64'(rsp_valid_o), 64'h0);
      end
      tick();
      rd_chk("mrst_sh0", 0, 1'b1, 8'h00, 1'b0);
      rd_chk("mrst_act0", 0, 1'b0, 8'h00, 1'b0);
      xact(OP_WRITE, 3, 8'h5A, rd, re);
      chk("mrst_wr", 64'(rd), 64'h5A);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
